seg7_scan_ctrl: RTL and testbench

//  Controller for the two-digit 7-segment display path. Accepts a 7-bit count via

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/bcd_seq_conv.sv | 80 ++++++++
 rtl/seg7_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared state types, segment constants and the digit decoder for
//             the two-digit 7-segment scan controller.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    typedef enum logic [1:0] {
        SHOW_T   = 2'd0,
        BLANK_TU = 2'd1,
        SHOW_U   = 2'd2,
        BLANK_UT = 2'd3
    } scan_state_t;

    localparam logic [7:0] SEG_ERR = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Digit 0 sits in the least-significant byte, {dp,g..a} per byte.
    localparam logic [79:0] c_SEG_TABLE = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [7:0] seg7_decode(input logic [3:0] digit);
        logic [7:0] seg_val;
        seg_val = SEG_ERR;
        if (digit <= 4'd9) begin
            seg_val = c_SEG_TABLE[{digit, 3'b000} +: 8];
        end
        return seg_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seq_conv
//  Purpose  : Sequential 7-bit binary to two-digit BCD converter (double-dabble)
//             with a valid/ready input and a one-cycle done strobe.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_seq_conv
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_value,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    conv_state_t  r_state;
    logic [2:0]   r_step;
    logic [16:0]  r_shift;   // {hund[1:0], tens, units, binary}
    logic [16:0]  w_adj;

    always_comb begin
        w_adj = r_shift;
        if (r_shift[10:7] >= 4'd5) begin
            w_adj[10:7] = r_shift[10:7] + 4'd3;
        end
        if (r_shift[14:11] >= 4'd5) begin
            w_adj[14:11] = r_shift[14:11] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
            r_shift <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        r_shift <= {10'd0, i_value};
                        r_step  <= 3'd0;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        r_state <= CONV;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                CONV: begin
                    r_shift <= w_adj << 1;
                    r_step  <= r_step + 3'd1;
                    if (r_step == 3'd6) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Values above 99 carry a hundreds digit; flag them with an out-of-range nibble.
    assign o_done  = (r_state == LOAD);
    assign o_tens  = (r_shift[16:15] != 2'd0) ? 4'hF : r_shift[14:11];
    assign o_units = (r_shift[16:15] != 2'd0) ? 4'hF : r_shift[10:7];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Two-digit 7-segment controller: BCD conversion of an accepted count
//             and time-multiplexed scan of a shared segment bus with blanking gaps.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int   SCAN_DIV  = 50000,
    parameter int   BLANK_CYC = 16,
    parameter logic LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] value,
    input  logic       value_valid,
    output logic       value_ready,
    output logic [7:0] seg,
    output logic       dig_t_ena,
    output logic       dig_u_ena,
    output logic       busy
);

    localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);

    scan_state_t        r_scan_state;
    scan_state_t        w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_term;
    logic [3:0]         r_disp_tens;
    logic [3:0]         r_disp_units;
    logic               w_conv_done;
    logic [3:0]         w_conv_tens;
    logic [3:0]         w_conv_units;

    bcd_seq_conv u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_value (value),
        .i_valid (value_valid),
        .o_ready (value_ready),
        .o_busy  (busy),
        .o_done  (w_conv_done),
        .o_tens  (w_conv_tens),
        .o_units (w_conv_units)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_tens  <= 4'd0;
            r_disp_units <= 4'd0;
        end else if (w_conv_done) begin
            r_disp_tens  <= w_conv_tens;
            r_disp_units <= w_conv_units;
        end
    end

    always_comb begin
        w_next_state = r_scan_state;
        w_term       = 1'b0;
        case (r_scan_state)
            SHOW_T: begin
                w_term       = (r_cnt == c_SHOW_LAST);
                w_next_state = BLANK_TU;
            end
            BLANK_TU: begin
                w_term       = (r_cnt == c_BLANK_LAST);
                w_next_state = SHOW_U;
            end
            SHOW_U: begin
                w_term       = (r_cnt == c_SHOW_LAST);
                w_next_state = BLANK_UT;
            end
            BLANK_UT: begin
                w_term       = (r_cnt == c_BLANK_LAST);
                w_next_state = SHOW_T;
            end
            default: begin
                w_term       = 1'b1;
                w_next_state = SHOW_T;
            end
        endcase
    end

    // The segment register is loaded only at slot entry, so it doubles as the
    // active-digit copy: a display update mid-slot cannot disturb a lit digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_state <= SHOW_T;
            r_cnt        <= '0;
            seg          <= SEG_OFF;
            dig_t_ena    <= 1'b1;
            dig_u_ena    <= 1'b1;
        end else if (w_term) begin
            r_cnt        <= '0;
            r_scan_state <= w_next_state;
            case (w_next_state)
                SHOW_T: begin
                    dig_u_ena <= 1'b1;
                    if (LZ_BLANK && (r_disp_tens == 4'd0)) begin
                        seg       <= SEG_OFF;
                        dig_t_ena <= 1'b1;
                    end else begin
                        seg       <= seg7_decode(r_disp_tens);
                        dig_t_ena <= 1'b0;
                    end
                end
                SHOW_U: begin
                    seg       <= seg7_decode(r_disp_units);
                    dig_t_ena <= 1'b1;
                    dig_u_ena <= 1'b0;
                end
                default: begin
                    seg       <= SEG_OFF;
                    dig_t_ena <= 1'b1;
                    dig_u_ena <= 1'b1;
                end
            endcase
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Randomised self-checking bench for seg7_scan_ctrl against a
//             cycle-level behavioural model of the display.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int T = 4;
    localparam int B = 2;
    localparam int P = 2 * (T + B);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] value = 7'd0;
    logic       value_valid = 1'b0;
    logic       value_ready;
    logic [7:0] seg;
    logic       dig_t_ena;
    logic       dig_u_ena;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    seg7_scan_ctrl #(.SCAN_DIV(T), .BLANK_CYC(B), .LZ_BLANK(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .seg         (seg),
        .dig_t_ena   (dig_t_ena),
        .dig_u_ena   (dig_u_ena),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Display model: what a viewer should see, derived from the value and time.
    logic [7:0] seg_tbl [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    typedef struct packed {
        int         edge_n;
        int         busy_left;
        int         cap;
        int         disp;
        logic       ready;
        logic [7:0] seg;
        logic       t;
        logic       u;
    } model_t;

    function automatic model_t model_reset();
        model_t s;
        s = '0;
        s.t = 1'b1;
        s.u = 1'b1;
        return s;
    endfunction

    function automatic model_t model_step(model_t s, logic vv, logic [6:0] v);
        model_t n;
        int     p;
        n = s;
        if (s.busy_left > 0) begin
            n.busy_left = s.busy_left - 1;
            if (n.busy_left == 0) begin
                n.disp  = s.cap;
                n.ready = 1'b1;
            end
        end else if (s.ready && vv) begin
            n.cap       = int'(v);
            n.ready     = 1'b0;
            n.busy_left = 8;
        end else begin
            n.ready = 1'b1;
        end
        n.edge_n = s.edge_n + 1;
        p = n.edge_n % P;
        // Slot contents come from the value displayed before this edge.
        if (p == 0) begin
            n.u = 1'b1;
            if (s.disp > 99) begin
                n.seg = 8'hFF; n.t = 1'b0;
            end else if (s.disp / 10 == 0) begin
                n.seg = 8'h00; n.t = 1'b1;
            end else begin
                n.seg = seg_tbl[s.disp / 10]; n.t = 1'b0;
            end
        end else if (p == T + B) begin
            n.t   = 1'b1;
            n.u   = 1'b0;
            n.seg = (s.disp > 99) ? 8'hFF : seg_tbl[s.disp % 10];
        end else if (p == T || p == 2 * T + B) begin
            n.seg = 8'h00; n.t = 1'b1; n.u = 1'b1;
        end
        return n;
    endfunction

    model_t m = model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, value_valid, value);
    end

    always @(negedge clk) begin
        check("seg", 32'(seg), 32'(m.seg));
        check("dig_t_ena", 32'(dig_t_ena), 32'(m.t));
        check("dig_u_ena", 32'(dig_u_ena), 32'(m.u));
        check("value_ready", 32'(value_ready), 32'(m.ready));
        check("busy", 32'(busy), 32'(m.busy_left > 0));
        check("overlap", 32'(!dig_t_ena && !dig_u_ena), 32'd0);
        if (dig_t_ena && dig_u_ena) check("dark_seg", 32'(seg), 32'd0);
    end

    int last_acc = 0;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [6:0] v, input bit hold);
        int n;
        n = 0;
        value       = v;
        value_valid = 1'b1;
        while (!value_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check("ready_timeout", 32'd0, 32'd1);
            value_valid = 1'b0;
        end else begin
            last_acc = cyc + 1;
            @(negedge clk);
            if (!hold) value_valid = 1'b0;
        end
    endtask

    initial begin
        int first_acc;
        int stop_cyc;
        int gap;
        bit hold;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * P) @(negedge clk);

        send(7'd47, 1'b0);
        repeat (3 * P) @(negedge clk);

        send(7'd100, 1'b0);
        repeat (3 * P) @(negedge clk);

        send(7'd9, 1'b1);
        first_acc = last_acc;
        send(7'd58, 1'b0);
        check("b2b_gap", 32'(last_acc - first_acc), 32'd9);
        repeat (3 * P) @(negedge clk);

        send(7'd63, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_t_ena", 32'(dig_t_ena), 32'd1);
        check("rst_u_ena", 32'(dig_u_ena), 32'd1);
        check("rst_ready", 32'(value_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * P) @(negedge clk);

        stop_cyc = cyc + 1000 * P;
        while (cyc < stop_cyc) begin
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) send(7'($urandom_range(100, 127)), hold);
            else                           send(7'($urandom_range(0, 99)), hold);
            gap = hold ? 0 : $urandom_range(0, 3 * P);
            repeat (gap) @(negedge clk);
        end
        value_valid = 1'b0;
        repeat (2 * P) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
